// File: rtl/instr_fetch_mem.sv
// Instruction-side memory for the program counter.
// Two phases: LOAD streams program words in over a valid/ready port while the
// core is held busy. RUN then serves fetches with one-cycle registered latency.
// Priority in RUN is STALL over PCSRC (branch squash) over a normal fetch.
module instr_fetch_mem #(
  parameter int                 DATA_W = 16,
  parameter int                 ADDR_W = 8,
  parameter logic [DATA_W-1:0]  NOP    = 16'h0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] address,
  input  logic              STALL,
  input  logic              PCSRC,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              busy,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   ld_ptr_r;
  logic [ADDR_W-1:0]   ld_ptr_next_s;
  logic                ld_xfer_s;
  logic [DATA_W-1:0]   instr_r;
  logic [DATA_W-1:0]   instr_next_s;
  logic                instr_valid_r;
  logic                instr_valid_next_s;
  logic                addr_err_r;
  logic                addr_err_next_s;
  logic                in_range_s;
  logic [DATA_W-1:0]   addr_hi_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  // Upper address bits beyond the array index must all be zero for a legal fetch.
  always_comb begin
    addr_hi_s  = address >> ADDR_W;
    in_range_s = (addr_hi_s == {DATA_W{1'b0}});
  end

  // Next-state, loader handshake and fetch-output decisions.
  always_comb begin
    state_next_s       = state_r;
    ld_ptr_next_s      = ld_ptr_r;
    ld_xfer_s          = 1'b0;
    instr_next_s       = instr_r;
    instr_valid_next_s = instr_valid_r;
    addr_err_next_s    = addr_err_r;
    case (state_r)
      ST_LOAD: begin
        instr_next_s       = NOP;
        instr_valid_next_s = 1'b0;
        // A reset edge must never also commit a loader write.
        if (ld_valid && !RST) begin
          ld_xfer_s     = 1'b1;
          ld_ptr_next_s = ld_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          // Last slot ends the load on its own so word 0 is never overwritten.
          if (ld_last || (ld_ptr_r == {ADDR_W{1'b1}})) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_LOAD;
          end
        end else begin
          ld_xfer_s     = 1'b0;
          ld_ptr_next_s = ld_ptr_r;
        end
      end
      ST_RUN: begin
        if (STALL) begin
          instr_next_s       = instr_r;
          instr_valid_next_s = instr_valid_r;
          addr_err_next_s    = addr_err_r;
        end else if (PCSRC) begin
          instr_next_s       = NOP;
          instr_valid_next_s = 1'b0;
        end else if (in_range_s) begin
          instr_next_s       = mem_r[address[ADDR_W-1:0]];
          instr_valid_next_s = 1'b1;
        end else begin
          instr_next_s       = NOP;
          instr_valid_next_s = 1'b0;
          addr_err_next_s    = 1'b1;
        end
      end
      default: begin
        state_next_s       = ST_LOAD;
        instr_next_s       = NOP;
        instr_valid_next_s = 1'b0;
      end
    endcase
  end

  // State, load pointer and registered fetch outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_LOAD;
      ld_ptr_r      <= {ADDR_W{1'b0}};
      instr_r       <= NOP;
      instr_valid_r <= 1'b0;
      addr_err_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      ld_ptr_r      <= ld_ptr_next_s;
      instr_r       <= instr_next_s;
      instr_valid_r <= instr_valid_next_s;
      addr_err_r    <= addr_err_next_s;
    end
  end

  // Program array write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (ld_xfer_s) begin
      mem_r[ld_ptr_r] <= ld_data;
    end
  end

  // Handshake outputs are decoded directly from the state register.
  always_comb begin
    ld_ready    = (state_r == ST_LOAD);
    busy        = (state_r == ST_LOAD);
    instr       = instr_r;
    instr_valid = instr_valid_r;
    addr_err    = addr_err_r;
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: load/run phases, stall, flush,
// out-of-range fetch and full-array fill, using a scoreboard queue.
module tb_instr_fetch_mem;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] address;
  logic        STALL;
  logic        PCSRC;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        busy;
  logic [15:0] instr;
  logic        instr_valid;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_mem [256];
  int          model_ptr;
  logic [15:0] m_instr;
  logic        m_valid;
  logic        m_err;

  instr_fetch_mem #(.DATA_W(16), .ADDR_W(8), .NOP(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .address(address), .STALL(STALL), .PCSRC(PCSRC),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .busy(busy), .instr(instr),
    .instr_valid(instr_valid), .addr_err(addr_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    ld_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    RST = 1'b0;
    model_ptr = 0;
    m_instr = 16'h0000;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // one loader transfer after `gap` idle cycles (ld_ready/instr checked during gaps)
  task automatic load_word(input logic [15:0] d, input logic last, input int gap);
    for (int g = 0; g < gap; g++) begin
      ld_valid = 1'b0;
      tick();
      checks++;
      if (ld_ready !== 1'b1 || instr !== 16'h0000 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_gap: ld_ready=%b instr=%h valid=%b expected 1/0000/0",
                 ld_ready, instr, instr_valid);
      end
    end
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    model_mem[model_ptr] = d;
    model_ptr++;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // drive one RUN cycle, push expectation, then pop and compare after the edge
  task automatic run_cycle(input string name, input logic [15:0] a,
                           input logic st, input logic pc);
    exp_t e;
    address = a;
    STALL   = st;
    PCSRC   = pc;
    if (st) begin
      // hold
    end else if (pc) begin
      m_instr = 16'h0000;
      m_valid = 1'b0;
    end else if (a[15:8] == 8'h00) begin
      m_instr = model_mem[a[7:0]];
      m_valid = 1'b1;
    end else begin
      m_instr = 16'h0000;
      m_valid = 1'b0;
      m_err   = 1'b1;
    end
    sb_q.push_back('{instr: m_instr, valid: m_valid, err: m_err});
    tick();
    e = sb_q.pop_front();
    checks++;
    if (instr !== e.instr || instr_valid !== e.valid || addr_err !== e.err) begin
      errors++;
      $display("FAIL %s: addr=%h got instr=%h valid=%b err=%b expected %h/%b/%b",
               name, a, instr, instr_valid, addr_err, e.instr, e.valid, e.err);
    end
    STALL = 1'b0;
    PCSRC = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (instr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_instr: got %h expected 0000", instr);
    end
    check_bit("reset_valid", instr_valid, 1'b0);
    check_bit("reset_ld_ready", ld_ready, 1'b1);
    check_bit("reset_busy", busy, 1'b1);
    check_bit("reset_addr_err", addr_err, 1'b0);
  endtask

  task automatic test_load();
    // address/STALL/PCSRC activity must be ignored while loading
    address = 16'h0003;
    STALL   = 1'b0;
    PCSRC   = 1'b1;
    load_word(16'hA001, 1'b0, 1);
    PCSRC   = 1'b0;
    load_word(16'hA002, 1'b0, 2);
    check_bit("load_ready_mid", ld_ready, 1'b1);
    load_word(16'hA003, 1'b0, 0);
    load_word(16'hA004, 1'b1, 3);
    check_bit("load_ready_drop", ld_ready, 1'b0);
    check_bit("load_busy_drop", busy, 1'b0);
    for (int i = 0; i < 4; i++) run_cycle("fetch_seq", 16'(i), 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) run_cycle("stall_hold", 16'h0002, 1'b1, 1'b0);
    run_cycle("stall_release", 16'h0002, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    run_cycle("flush", 16'h0001, 1'b0, 1'b1);
    run_cycle("after_flush", 16'h0001, 1'b0, 1'b0);
    run_cycle("flush_stall_wins", 16'h0003, 1'b1, 1'b1);
    run_cycle("post_stall_flush", 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_addr_err();
    run_cycle("oor_fetch", 16'h0100, 1'b0, 1'b0);
    run_cycle("err_sticky_a", 16'h0002, 1'b0, 1'b0);
    run_cycle("err_sticky_b", 16'h00FF, 1'b0, 1'b0);
    run_cycle("oor_high", 16'h8003, 1'b0, 1'b0);
    run_cycle("err_sticky_c", 16'h0003, 1'b0, 1'b0);
  endtask

  task automatic test_fill();
    do_reset(1);
    check_bit("fill_err_cleared", addr_err, 1'b0);
    for (int i = 0; i < 256; i++) begin
      load_word(16'h5000 + 16'(i), 1'b0, 0);
      if (i == 254) check_bit("fill_ready_254", ld_ready, 1'b1);
    end
    check_bit("fill_ready_end", ld_ready, 1'b0);
    // loader activity in RUN must not write the array
    ld_valid = 1'b1;
    ld_data  = 16'hDEAD;
    address  = 16'h0000;
    tick();
    tick();
    ld_valid = 1'b0;
    run_cycle("fill_word0", 16'h0000, 1'b0, 1'b0);
    run_cycle("fill_word255", 16'h00FF, 1'b0, 1'b0);
    run_cycle("fill_word128", 16'h0080, 1'b0, 1'b0);
  endtask

  task automatic test_reload_reset();
    do_reset(1);
    for (int i = 0; i < 10; i++) load_word(16'h6000 + 16'(i), 1'b0, 0);
    do_reset(1);
    check_bit("reload_ready", ld_ready, 1'b1);
    load_word(16'h7777, 1'b1, 0);
    check_bit("reload_run", busy, 1'b0);
    run_cycle("reload_w0", 16'h0000, 1'b0, 1'b0);
    run_cycle("reload_w1", 16'h0001, 1'b0, 1'b0);
    run_cycle("reload_w9", 16'h0009, 1'b0, 1'b0);
    run_cycle("reload_w10", 16'h000A, 1'b0, 1'b0);
    run_cycle("reload_w255", 16'h00FF, 1'b0, 1'b0);
  endtask

  initial begin
    RST      = 1'b1;
    address  = 16'h0000;
    STALL    = 1'b0;
    PCSRC    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 16'h0000;
    ld_last  = 1'b0;
    model_ptr = 0;
    m_instr = 16'h0000;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 16'hxxxx;
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_addr_err();
    test_fill();
    test_reload_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
